// File: rtl/rob_commit_unit_if.sv
// ROB-head / register-file bundle for the commit unit. The slave modport is the
// commit unit; the master modport is the ROB/environment side.
interface rob_commit_unit_if #(
    parameter int unsigned ROB_WIDTH = 26,
    parameter int unsigned DATA_W    = ROB_WIDTH - 8,
    parameter int unsigned CNT_W     = 16
);
    logic [ROB_WIDTH-1:0] rob_entry_i;
    logic                 rob_empty_i;
    logic                 rob_pop_o;
    logic                 rf_wen_o;
    logic [4:0]           rf_waddr_o;
    logic [DATA_W-1:0]    rf_wdata_o;
    logic                 exc_valid_o;
    logic [DATA_W-1:0]    exc_data_o;
    logic                 flush_active_o;
    logic [CNT_W-1:0]     retire_cnt_o;
    logic                 hang_o;

    modport slave (
        input  rob_entry_i, rob_empty_i,
        output rob_pop_o, rf_wen_o, rf_waddr_o, rf_wdata_o, exc_valid_o,
               exc_data_o, flush_active_o, retire_cnt_o, hang_o
    );

    modport master (
        output rob_entry_i, rob_empty_i,
        input  rob_pop_o, rf_wen_o, rf_waddr_o, rf_wdata_o, exc_valid_o,
               exc_data_o, flush_active_o, retire_cnt_o, hang_o
    );
endinterface

// File: rtl/rob_commit_unit.sv
// Retire stage behind the ROB head: registers completed entries into RF writes,
// flushes the ROB after a retired exception and watches for a stalled head.
module rob_commit_unit #(
    parameter int unsigned ROB_WIDTH = 26,
    parameter int unsigned DATA_W    = ROB_WIDTH - 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    rob_commit_unit_if.slave   bus
);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e             state_q, state_d;
    logic               rf_wen_q, rf_wen_d;
    logic [4:0]         rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
    logic               exc_valid_q, exc_valid_d;
    logic [DATA_W-1:0]  exc_data_q, exc_data_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               hang_q, hang_d;

    logic               e_done, e_wen, e_exc;
    logic [4:0]         e_rd;
    logic [DATA_W-1:0]  e_result;

    assign e_done   = bus.rob_entry_i[0];
    assign e_wen    = bus.rob_entry_i[1];
    assign e_rd     = bus.rob_entry_i[6:2];
    assign e_exc    = bus.rob_entry_i[7];
    assign e_result = bus.rob_entry_i[ROB_WIDTH-1:8];

    always_comb begin
        state_d      = state_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        exc_valid_d  = 1'b0;
        exc_data_d   = exc_data_q;
        retire_cnt_d = retire_cnt_q;
        wd_d         = '0;
        case (state_q)
            RUN: begin
                if (e_done) begin
                    if (e_exc) begin
                        exc_valid_d = 1'b1;
                        exc_data_d  = e_result;
                        state_d     = FLUSH;
                    end else begin
                        rf_wen_d     = e_wen && (e_rd != 5'd0);
                        rf_waddr_d   = e_rd;
                        rf_wdata_d   = e_result;
                        retire_cnt_d = retire_cnt_q + CNT_W'(1);
                    end
                end else if (!bus.rob_empty_i) begin
                    // Saturate so a long stall cannot wrap back below TIMEOUT.
                    wd_d = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
                end
            end
            FLUSH: begin
                if (bus.rob_empty_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        hang_d = hang_q || (wd_d == WD_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            exc_valid_q  <= 1'b0;
            exc_data_q   <= '0;
            retire_cnt_q <= '0;
            wd_q         <= '0;
            hang_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            exc_valid_q  <= exc_valid_d;
            exc_data_q   <= exc_data_d;
            retire_cnt_q <= retire_cnt_d;
            wd_q         <= wd_d;
            hang_q       <= hang_d;
        end
    end

    // The ROB ORs this with its own done-pop, so a done head in FLUSH pops once.
    assign bus.rob_pop_o      = (state_q == FLUSH) && !bus.rob_empty_i;
    assign bus.flush_active_o = (state_q == FLUSH);
    assign bus.rf_wen_o       = rf_wen_q;
    assign bus.rf_waddr_o     = rf_waddr_q;
    assign bus.rf_wdata_o     = rf_wdata_q;
    assign bus.exc_valid_o    = exc_valid_q;
    assign bus.exc_data_o     = exc_data_q;
    assign bus.retire_cnt_o   = retire_cnt_q;
    assign bus.hang_o         = hang_q;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit (ROB_WIDTH=26, CNT_W=4, TIMEOUT=16).
module tb_rob_commit_unit;
    localparam int unsigned RW = 26;
    localparam int unsigned DW = RW - 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rob_commit_unit_if #(.ROB_WIDTH(RW), .DATA_W(DW), .CNT_W(CW)) bif ();

    rob_commit_unit #(.ROB_WIDTH(RW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    function automatic logic [RW-1:0] mk(input logic d, input logic w, input logic [4:0] rd,
                                         input logic e, input logic [DW-1:0] res);
        return {res, e, rd, w, d};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bif.rob_entry_i = '0;
        bif.rob_empty_i = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++; if (bif.rf_wen_o !== 1'b0) begin errors++; $display("FAIL rst_wen got=%0b exp=0", bif.rf_wen_o); end
        checks++; if (bif.retire_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", bif.retire_cnt_o); end
        checks++; if (bif.hang_o !== 1'b0) begin errors++; $display("FAIL rst_hang got=%0b exp=0", bif.hang_o); end
        checks++; if (bif.flush_active_o !== 1'b0 || bif.rob_pop_o !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0b/%0b exp=0/0", bif.flush_active_o, bif.rob_pop_o); end
        checks++; if (bif.exc_valid_o !== 1'b0 || bif.exc_data_o !== 18'd0) begin errors++; $display("FAIL rst_exc got=%0b/%h exp=0/0", bif.exc_valid_o, bif.exc_data_o); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_retire();
        bif.rob_empty_i = 1'b0;
        bif.rob_entry_i = mk(1, 1, 5'd3, 0, 18'h000AB);
        cycle();
        checks++; if (bif.rf_wen_o !== 1'b1 || bif.rf_waddr_o !== 5'd3 || bif.rf_wdata_o !== 18'h000AB)
            begin errors++; $display("FAIL ret_first got=%0b/%0d/%h exp=1/3/000ab", bif.rf_wen_o, bif.rf_waddr_o, bif.rf_wdata_o); end
        checks++; if (bif.retire_cnt_o !== 4'd1) begin errors++; $display("FAIL ret_cnt1 got=%0d exp=1", bif.retire_cnt_o); end
        bif.rob_entry_i = mk(1, 1, 5'd0, 0, 18'h00055);
        cycle();
        checks++; if (bif.rf_wen_o !== 1'b0) begin errors++; $display("FAIL ret_rd0 got=%0b exp=0", bif.rf_wen_o); end
        checks++; if (bif.retire_cnt_o !== 4'd2) begin errors++; $display("FAIL ret_cnt2 got=%0d exp=2", bif.retire_cnt_o); end
        bif.rob_entry_i = mk(1, 0, 5'd5, 0, 18'h00077);
        cycle();
        checks++; if (bif.rf_wen_o !== 1'b0) begin errors++; $display("FAIL ret_wen0 got=%0b exp=0", bif.rf_wen_o); end
        checks++; if (bif.retire_cnt_o !== 4'd3) begin errors++; $display("FAIL ret_cnt3 got=%0d exp=3", bif.retire_cnt_o); end
        bif.rob_entry_i = '0;
        bif.rob_empty_i = 1'b1;
        cycle();
        checks++; if (bif.rf_wen_o !== 1'b0 || bif.retire_cnt_o !== 4'd3) begin errors++; $display("FAIL ret_idle got=%0b/%0d exp=0/3", bif.rf_wen_o, bif.retire_cnt_o); end
    endtask

    task automatic test_exception_flush();
        int pops = 0;
        int fcyc = 0;
        int bad  = 0;
        bif.rob_empty_i = 1'b0;
        bif.rob_entry_i = mk(1, 1, 5'd2, 1, 18'h01234);
        cycle();
        checks++; if (bif.exc_valid_o !== 1'b1 || bif.exc_data_o !== 18'h01234)
            begin errors++; $display("FAIL exc_pulse got=%0b/%h exp=1/01234", bif.exc_valid_o, bif.exc_data_o); end
        checks++; if (bif.rf_wen_o !== 1'b0 || bif.retire_cnt_o !== 4'd3)
            begin errors++; $display("FAIL exc_norf got=%0b/%0d exp=0/3", bif.rf_wen_o, bif.retire_cnt_o); end
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                bif.rob_empty_i = 1'b0;
                bif.rob_entry_i = mk(1, 1, 5'd4, 1'(c & 1), DW'(c));
            end else begin
                bif.rob_empty_i = 1'b1;
                bif.rob_entry_i = '0;
            end
            #1;
            if (bif.rob_pop_o === 1'b1) pops++;
            if (bif.flush_active_o === 1'b1) fcyc++;
            cycle();
            if (bif.rf_wen_o !== 1'b0 || bif.exc_valid_o !== 1'b0) bad++;
        end
        checks++; if (pops != 4) begin errors++; $display("FAIL flush_pops got=%0d exp=4", pops); end
        checks++; if (fcyc != 5) begin errors++; $display("FAIL flush_cycles got=%0d exp=5", fcyc); end
        checks++; if (bad != 0) begin errors++; $display("FAIL flush_discard got=%0d exp=0", bad); end
        checks++; if (bif.retire_cnt_o !== 4'd3 || bif.exc_data_o !== 18'h01234)
            begin errors++; $display("FAIL flush_hold got=%0d/%h exp=3/01234", bif.retire_cnt_o, bif.exc_data_o); end
    endtask

    task automatic test_flush_empty();
        bif.rob_empty_i = 1'b0;
        bif.rob_entry_i = mk(1, 0, 5'd0, 1, 18'h00042);
        cycle();
        bif.rob_empty_i = 1'b1;
        bif.rob_entry_i = '0;
        #1;
        checks++; if (bif.flush_active_o !== 1'b1 || bif.rob_pop_o !== 1'b0)
            begin errors++; $display("FAIL fe_in got=%0b/%0b exp=1/0", bif.flush_active_o, bif.rob_pop_o); end
        cycle();
        checks++; if (bif.flush_active_o !== 1'b0) begin errors++; $display("FAIL fe_len got=%0b exp=0", bif.flush_active_o); end
        bif.rob_empty_i = 1'b0;
        bif.rob_entry_i = mk(1, 1, 5'd7, 0, 18'h0003C);
        cycle();
        checks++; if (bif.rf_wen_o !== 1'b1 || bif.rf_waddr_o !== 5'd7 || bif.rf_wdata_o !== 18'h0003C || bif.retire_cnt_o !== 4'd4)
            begin errors++; $display("FAIL fe_retire got=%0b/%0d/%h/%0d exp=1/7/0003c/4", bif.rf_wen_o, bif.rf_waddr_o, bif.rf_wdata_o, bif.retire_cnt_o); end
    endtask

    task automatic test_watchdog();
        bif.rob_empty_i = 1'b0;
        bif.rob_entry_i = RW'(26'h0000002);
        repeat (10) cycle();
        bif.rob_entry_i = mk(1, 0, 5'd0, 0, 18'h0);
        cycle();
        bif.rob_entry_i = RW'(26'h0000002);
        repeat (10) cycle();
        checks++; if (bif.hang_o !== 1'b0) begin errors++; $display("FAIL wd_cleared got=%0b exp=0", bif.hang_o); end
        bif.rob_empty_i = 1'b1;
        bif.rob_entry_i = '0;
        cycle();
        bif.rob_empty_i = 1'b0;
        bif.rob_entry_i = RW'(26'h0000002);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            if (k == 15) begin
                checks++; if (bif.hang_o !== 1'b0) begin errors++; $display("FAIL wd_c15 got=%0b exp=0", bif.hang_o); end
            end
        end
        checks++; if (bif.hang_o !== 1'b1) begin errors++; $display("FAIL wd_c16 got=%0b exp=1", bif.hang_o); end
        bif.rob_entry_i = mk(1, 0, 5'd0, 0, 18'h0);
        cycle();
        bif.rob_empty_i = 1'b1;
        bif.rob_entry_i = '0;
        repeat (2) cycle();
        checks++; if (bif.hang_o !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%0b exp=1", bif.hang_o); end
    endtask

    task automatic test_back_to_back_wrap();
        logic [3:0] exp_cnt;
        rst = 1'b0;
        #2 rst = 1'b1;
        cycle();
        bif.rob_empty_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bif.rob_entry_i = mk(1, 1, 5'(i + 1), 0, DW'(i * 3 + 1));
            cycle();
            exp_cnt = 4'(i + 1);
            checks++; if (bif.rf_wen_o !== 1'b1 || bif.rf_waddr_o !== 5'(i + 1) || bif.rf_wdata_o !== DW'(i * 3 + 1) || bif.retire_cnt_o !== exp_cnt)
                begin errors++; $display("FAIL b2b_%0d got=%0b/%0d/%h/%0d exp=1/%0d/%h/%0d", i, bif.rf_wen_o, bif.rf_waddr_o, bif.rf_wdata_o, bif.retire_cnt_o, i + 1, DW'(i * 3 + 1), exp_cnt); end
        end
        bif.rob_entry_i = '0;
        bif.rob_empty_i = 1'b1;
        cycle();
        checks++; if (bif.retire_cnt_o !== 4'd1) begin errors++; $display("FAIL wrap_cnt got=%0d exp=1", bif.retire_cnt_o); end
    endtask

    task automatic test_reset_mid_flush();
        bif.rob_empty_i = 1'b0;
        bif.rob_entry_i = mk(1, 0, 5'd0, 1, 18'h00099);
        cycle();
        bif.rob_entry_i = RW'(26'h0000002);
        #1;
        checks++; if (bif.rob_pop_o !== 1'b1) begin errors++; $display("FAIL rmf_pre got=%0b exp=1", bif.rob_pop_o); end
        rst = 1'b0;
        #1;
        checks++; if (bif.rob_pop_o !== 1'b0 || bif.flush_active_o !== 1'b0)
            begin errors++; $display("FAIL rmf_async got=%0b/%0b exp=0/0", bif.rob_pop_o, bif.flush_active_o); end
        checks++; if (bif.retire_cnt_o !== 4'd0 || bif.hang_o !== 1'b0 || bif.exc_data_o !== 18'd0)
            begin errors++; $display("FAIL rmf_clr got=%0d/%0b/%h exp=0/0/0", bif.retire_cnt_o, bif.hang_o, bif.exc_data_o); end
        cycle();
        rst = 1'b1;
        cycle();
        checks++; if (bif.flush_active_o !== 1'b0 || bif.rob_pop_o !== 1'b0)
            begin errors++; $display("FAIL rmf_run got=%0b/%0b exp=0/0", bif.flush_active_o, bif.rob_pop_o); end
        bif.rob_entry_i = mk(1, 1, 5'd9, 0, 18'h00321);
        cycle();
        checks++; if (bif.rf_wen_o !== 1'b1 || bif.rf_waddr_o !== 5'd9 || bif.retire_cnt_o !== 4'd1)
            begin errors++; $display("FAIL rmf_retire got=%0b/%0d/%0d exp=1/9/1", bif.rf_wen_o, bif.rf_waddr_o, bif.retire_cnt_o); end
    endtask

    initial begin
        test_reset();
        cycle();
        test_retire();
        test_exception_flush();
        test_flush_empty();
        test_watchdog();
        test_back_to_back_wrap();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
